// File: rtl/clk_rst_seq_if.sv
// rtl/clk_rst_seq_if.sv - lock/retry inputs and reset/status outputs of clk_rst_seq
interface clk_rst_seq_if;
    logic       i_locked;
    logic       i_retry;
    logic       o_mmcm_reset;
    logic       o_sys_reset;
    logic       o_ready;
    logic       o_fault;
    logic [7:0] o_relock_count;
    logic [2:0] o_state;

    modport master (
        output i_locked,
        output i_retry,
        input  o_mmcm_reset,
        input  o_sys_reset,
        input  o_ready,
        input  o_fault,
        input  o_relock_count,
        input  o_state
    );

    modport slave (
        input  i_locked,
        input  i_retry,
        output o_mmcm_reset,
        output o_sys_reset,
        output o_ready,
        output o_fault,
        output o_relock_count,
        output o_state
    );
endinterface

// File: rtl/clk_rst_seq.sv
// rtl/clk_rst_seq.sv - MMCM reset/lock supervisor releasing the system reset on stable lock
module clk_rst_seq #(
    parameter int SYNC_STAGES         = 2,
    parameter int MMCM_RST_CYCLES     = 8,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int RST_HOLD_CYCLES     = 16,
    parameter int MAX_RETRIES         = 3
) (
    input  logic         i_clk,
    input  logic         i_reset,
    clk_rst_seq_if.slave bus
);
    localparam int RST_W = (MMCM_RST_CYCLES > 1) ? $clog2(MMCM_RST_CYCLES) : 1;
    localparam int TO_W  = (LOCK_TIMEOUT_CYCLES > 1) ? $clog2(LOCK_TIMEOUT_CYCLES) : 1;
    localparam int STB_W = (LOCK_STABLE_CYCLES > 1) ? $clog2(LOCK_STABLE_CYCLES) : 1;
    localparam int HLD_W = (RST_HOLD_CYCLES > 1) ? $clog2(RST_HOLD_CYCLES) : 1;
    localparam int RTY_W = $clog2(MAX_RETRIES + 1);

    localparam logic [RST_W-1:0] RST_LAST = RST_W'(MMCM_RST_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [STB_W-1:0] STB_LAST = STB_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [HLD_W-1:0] HLD_LAST = HLD_W'(RST_HOLD_CYCLES - 1);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRIES);

    typedef enum logic [2:0] {
        ST_MMCM_RST  = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_HOLD      = 3'd3,
        ST_RUN       = 3'd4,
        ST_FAULT     = 3'd5
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [RST_W-1:0]       rst_cnt_q, rst_cnt_d;
    logic [TO_W-1:0]        to_cnt_q, to_cnt_d;
    logic [STB_W-1:0]       stb_cnt_q, stb_cnt_d;
    logic [HLD_W-1:0]       hld_cnt_q, hld_cnt_d;
    logic [RTY_W-1:0]       retry_q, retry_d;
    logic [RTY_W-1:0]       retry_inc;
    logic [7:0]             relock_q, relock_d;
    logic                   mmcm_reset_q, mmcm_reset_d;
    logic                   sys_reset_q, sys_reset_d;
    logic                   ready_q, ready_d;
    logic                   fault_q, fault_d;
    logic                   locked_s;

    assign locked_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], bus.i_locked};
    end

    always_comb begin
        state_d   = state_q;
        rst_cnt_d = rst_cnt_q;
        to_cnt_d  = to_cnt_q;
        stb_cnt_d = stb_cnt_q;
        hld_cnt_d = hld_cnt_q;
        retry_d   = retry_q;
        relock_d  = relock_q;
        retry_inc = retry_q + RTY_W'(1);

        case (state_q)
            ST_MMCM_RST: begin
                to_cnt_d = '0;
                if (rst_cnt_q == RST_LAST) begin
                    state_d   = ST_WAIT_LOCK;
                    rst_cnt_d = '0;
                end else begin
                    rst_cnt_d = rst_cnt_q + RST_W'(1);
                end
            end
            ST_WAIT_LOCK: begin
                // lock takes priority over a timeout landing on the same cycle
                if (locked_s) begin
                    state_d   = ST_STABLE;
                    stb_cnt_d = '0;
                end else if (to_cnt_q == TO_LAST) begin
                    retry_d   = retry_inc;
                    rst_cnt_d = '0;
                    state_d   = (retry_inc == RTY_MAX) ? ST_FAULT : ST_MMCM_RST;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            ST_STABLE: begin
                // timeout timer is frozen here, so glitches cannot reset the lock deadline
                if (!locked_s) begin
                    state_d = ST_WAIT_LOCK;
                end else if (stb_cnt_q == STB_LAST) begin
                    state_d   = ST_HOLD;
                    hld_cnt_d = '0;
                end else begin
                    stb_cnt_d = stb_cnt_q + STB_W'(1);
                end
            end
            ST_HOLD: begin
                if (!locked_s) begin
                    state_d = ST_WAIT_LOCK;
                end else if (hld_cnt_q == HLD_LAST) begin
                    state_d = ST_RUN;
                    retry_d = '0;
                end else begin
                    hld_cnt_d = hld_cnt_q + HLD_W'(1);
                end
            end
            ST_RUN: begin
                if (!locked_s) begin
                    state_d   = ST_MMCM_RST;
                    rst_cnt_d = '0;
                    if (relock_q != 8'hFF) begin
                        relock_d = relock_q + 8'd1;
                    end
                end
            end
            ST_FAULT: begin
                if (bus.i_retry) begin
                    state_d   = ST_MMCM_RST;
                    rst_cnt_d = '0;
                    retry_d   = '0;
                end
            end
            default: begin
                state_d   = ST_MMCM_RST;
                rst_cnt_d = '0;
            end
        endcase

        mmcm_reset_d = (state_d == ST_MMCM_RST);
        sys_reset_d  = (state_d != ST_RUN);
        ready_d      = (state_d == ST_RUN);
        fault_d      = (state_d == ST_FAULT);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q      <= ST_MMCM_RST;
            sync_q       <= '0;
            rst_cnt_q    <= '0;
            to_cnt_q     <= '0;
            stb_cnt_q    <= '0;
            hld_cnt_q    <= '0;
            retry_q      <= '0;
            relock_q     <= '0;
            mmcm_reset_q <= 1'b1;
            sys_reset_q  <= 1'b1;
            ready_q      <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync_q       <= sync_d;
            rst_cnt_q    <= rst_cnt_d;
            to_cnt_q     <= to_cnt_d;
            stb_cnt_q    <= stb_cnt_d;
            hld_cnt_q    <= hld_cnt_d;
            retry_q      <= retry_d;
            relock_q     <= relock_d;
            mmcm_reset_q <= mmcm_reset_d;
            sys_reset_q  <= sys_reset_d;
            ready_q      <= ready_d;
            fault_q      <= fault_d;
        end
    end

    assign bus.o_mmcm_reset   = mmcm_reset_q;
    assign bus.o_sys_reset    = sys_reset_q;
    assign bus.o_ready        = ready_q;
    assign bus.o_fault        = fault_q;
    assign bus.o_relock_count = relock_q;
    assign bus.o_state        = state_q;
endmodule

// File: tb/tb_clk_rst_seq.sv
// tb/tb_clk_rst_seq.sv - scoreboard bench for clk_rst_seq
module tb_clk_rst_seq;
    localparam int SYNC = 2;
    localparam int RSTC = 4;
    localparam int TO   = 32;
    localparam int STB  = 8;
    localparam int HOLD = 4;
    localparam int RTY  = 3;
    localparam int REL  = SYNC + STB + HOLD;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   exp_q[$];

    clk_rst_seq_if bus ();

    clk_rst_seq #(
        .SYNC_STAGES(SYNC),
        .MMCM_RST_CYCLES(RSTC),
        .LOCK_TIMEOUT_CYCLES(TO),
        .LOCK_STABLE_CYCLES(STB),
        .RST_HOLD_CYCLES(HOLD),
        .MAX_RETRIES(RTY)
    ) dut (
        .i_clk(clk),
        .i_reset(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic int snap();
        return int'({17'd0, bus.o_state, bus.o_mmcm_reset, bus.o_sys_reset,
                     bus.o_ready, bus.o_fault, bus.o_relock_count});
    endfunction

    function automatic int exp_snap(input logic [2:0] st, input logic m, input logic s,
                                    input logic r, input logic f, input logic [7:0] rc);
        return int'({17'd0, st, m, s, r, f, rc});
    endfunction

    task automatic wait_state(input logic [2:0] s, input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            if (bus.o_state == s) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        int obs, e;
        rst = 1'b1;
        bus.i_locked = 1'b0;
        bus.i_retry = 1'b0;
        exp_q.push_back(exp_snap(3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0));
        repeat (3) @(negedge clk);
        obs = snap(); e = exp_q.pop_front(); total++;
        if (obs !== e) begin bad++; $display("FAIL reset_outputs got=%h want=%h", obs, e); end
    endtask

    task automatic test_release();
        int n, obs, e;
        exp_q.push_back(RSTC);
        rst = 1'b0;
        n = 0;
        while (bus.o_mmcm_reset && n < 100) begin n++; @(negedge clk); end
        e = exp_q.pop_front(); total++;
        if (n !== e) begin bad++; $display("FAIL mmcm_rst_width got=%0d want=%0d", n, e); end
        repeat (10) @(negedge clk);
        bus.i_locked = 1'b1;
        exp_q.push_back(REL);
        @(negedge clk);
        n = 0;
        while (bus.o_sys_reset && n < 200) begin @(negedge clk); n++; end
        e = exp_q.pop_front(); total++;
        if (n !== e) begin bad++; $display("FAIL release_latency got=%0d want=%0d", n, e); end
        exp_q.push_back(exp_snap(3'd4, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0));
        obs = snap(); e = exp_q.pop_front(); total++;
        if (obs !== e) begin bad++; $display("FAIL run_outputs got=%h want=%h", obs, e); end
    endtask

    task automatic test_timeout();
        int pulses, width, gap, obs, e, v;
        int widths[$];
        int gaps[$];
        logic prev;
        bit ok;
        rst = 1'b1;
        bus.i_locked = 1'b0;
        repeat (2) @(negedge clk);
        exp_q.push_back(RTY);
        for (int k = 0; k < RTY; k++) exp_q.push_back(RSTC);
        for (int k = 0; k < RTY; k++) exp_q.push_back(TO);
        rst = 1'b0;
        pulses = 0; width = 0; gap = 0; prev = 1'b0;
        for (int i = 0; i < 500 && !bus.o_fault; i++) begin
            if (bus.o_mmcm_reset) begin
                if (!prev) begin
                    pulses++;
                    if (pulses > 1) gaps.push_back(gap);
                end
                width++;
            end else begin
                if (prev) begin widths.push_back(width); width = 0; gap = 0; end
                gap++;
            end
            prev = bus.o_mmcm_reset;
            @(negedge clk);
        end
        gaps.push_back(gap);
        e = exp_q.pop_front(); total++;
        if (pulses !== e) begin bad++; $display("FAIL retry_pulses got=%0d want=%0d", pulses, e); end
        for (int k = 0; k < RTY; k++) begin
            v = (widths.size() > k) ? widths[k] : -1;
            e = exp_q.pop_front(); total++;
            if (v !== e) begin bad++; $display("FAIL pulse_width[%0d] got=%0d want=%0d", k, v, e); end
        end
        for (int k = 0; k < RTY; k++) begin
            v = (gaps.size() > k) ? gaps[k] : -1;
            e = exp_q.pop_front(); total++;
            if (v !== e) begin bad++; $display("FAIL timeout_gap[%0d] got=%0d want=%0d", k, v, e); end
        end
        exp_q.push_back(exp_snap(3'd5, 1'b0, 1'b1, 1'b0, 1'b1, 8'd0));
        obs = snap(); e = exp_q.pop_front(); total++;
        if (obs !== e) begin bad++; $display("FAIL fault_outputs got=%h want=%h", obs, e); end
        bus.i_locked = 1'b1;
        exp_q.push_back(exp_snap(3'd5, 1'b0, 1'b1, 1'b0, 1'b1, 8'd0));
        repeat (6) @(negedge clk);
        obs = snap(); e = exp_q.pop_front(); total++;
        if (obs !== e) begin bad++; $display("FAIL fault_ignores_lock got=%h want=%h", obs, e); end
        bus.i_retry = 1'b1;
        exp_q.push_back(exp_snap(3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0));
        @(negedge clk);
        bus.i_retry = 1'b0;
        obs = snap(); e = exp_q.pop_front(); total++;
        if (obs !== e) begin bad++; $display("FAIL retry_exit got=%h want=%h", obs, e); end
        wait_state(3'd4, 200, ok);
        total++;
        if (ok !== 1'b1) begin bad++; $display("FAIL run_after_retry got=%0d want=1", ok); end
    endtask

    task automatic test_glitch();
        int n, m, e;
        bit ok;
        rst = 1'b1;
        bus.i_locked = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 50 && bus.o_mmcm_reset; i++) @(negedge clk);
        bus.i_locked = 1'b1;
        wait_state(3'd2, 50, ok);
        total++;
        if (ok !== 1'b1) begin bad++; $display("FAIL reach_stable got=%0d want=1", ok); end
        repeat (3) @(negedge clk);
        bus.i_locked = 1'b0;
        @(negedge clk);
        bus.i_locked = 1'b1;
        exp_q.push_back(REL);
        exp_q.push_back(0);
        @(negedge clk);
        n = 0; m = 0;
        while (bus.o_sys_reset && n < 200) begin
            @(negedge clk);
            n++;
            if (bus.o_mmcm_reset) m++;
        end
        e = exp_q.pop_front(); total++;
        if (n !== e) begin bad++; $display("FAIL glitch_release got=%0d want=%0d", n, e); end
        e = exp_q.pop_front(); total++;
        if (m !== e) begin bad++; $display("FAIL glitch_mmcm_cycles got=%0d want=%0d", m, e); end
    endtask

    task automatic test_relock();
        int lat, obs, e;
        bit ok;
        bus.i_retry = 1'b1;
        exp_q.push_back(exp_snap(3'd4, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0));
        @(negedge clk);
        bus.i_retry = 1'b0;
        obs = snap(); e = exp_q.pop_front(); total++;
        if (obs !== e) begin bad++; $display("FAIL retry_ignored_in_run got=%h want=%h", obs, e); end
        exp_q.push_back(SYNC + 1);
        bus.i_locked = 1'b0;
        lat = -1;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            if (lat < 0 && bus.o_sys_reset && !bus.o_ready) lat = i;
        end
        bus.i_locked = 1'b1;
        e = exp_q.pop_front(); total++;
        if (lat < 1 || lat > e) begin bad++; $display("FAIL loss_latency got=%0d want<=%0d", lat, e); end
        exp_q.push_back(1);
        obs = int'(bus.o_relock_count); e = exp_q.pop_front(); total++;
        if (obs !== e) begin bad++; $display("FAIL relock_count got=%0d want=%0d", obs, e); end
        wait_state(3'd4, 200, ok);
        exp_q.push_back(exp_snap(3'd4, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1));
        obs = snap(); e = exp_q.pop_front(); total++;
        if (obs !== e) begin bad++; $display("FAIL resequence_run got=%h want=%h", obs, e); end
    endtask

    task automatic test_async_reset();
        int obs, e;
        bit ok;
        bus.i_locked = 1'b0;
        repeat (3) @(negedge clk);
        bus.i_locked = 1'b1;
        wait_state(3'd3, 200, ok);
        total++;
        if (ok !== 1'b1) begin bad++; $display("FAIL reach_hold got=%0d want=1", ok); end
        exp_q.push_back(exp_snap(3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0));
        #3 rst = 1'b1;
        #1;
        obs = snap(); e = exp_q.pop_front(); total++;
        if (obs !== e) begin bad++; $display("FAIL async_reset got=%h want=%h", obs, e); end
        @(negedge clk);
    endtask

    task automatic test_saturation();
        int c254, c255, stuck, obs, e;
        bit ok;
        bus.i_locked = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_state(3'd4, 200, ok);
        c254 = -1; c255 = -1; stuck = 0;
        exp_q.push_back(0);
        exp_q.push_back(254);
        exp_q.push_back(255);
        exp_q.push_back(255);
        for (int k = 1; k <= 260; k++) begin
            bus.i_locked = 1'b0;
            repeat (3) @(negedge clk);
            bus.i_locked = 1'b1;
            @(negedge clk);
            wait_state(3'd4, 100, ok);
            if (!ok) stuck++;
            if (k == 254) c254 = int'(bus.o_relock_count);
            if (k == 255) c255 = int'(bus.o_relock_count);
        end
        e = exp_q.pop_front(); total++;
        if (stuck !== e) begin bad++; $display("FAIL relock_timeouts got=%0d want=%0d", stuck, e); end
        e = exp_q.pop_front(); total++;
        if (c254 !== e) begin bad++; $display("FAIL relock_254 got=%0d want=%0d", c254, e); end
        e = exp_q.pop_front(); total++;
        if (c255 !== e) begin bad++; $display("FAIL relock_255 got=%0d want=%0d", c255, e); end
        obs = int'(bus.o_relock_count); e = exp_q.pop_front(); total++;
        if (obs !== e) begin bad++; $display("FAIL relock_saturate got=%0d want=%0d", obs, e); end
    endtask

    initial begin
        bus.i_locked = 1'b0;
        bus.i_retry = 1'b0;
        test_reset();
        test_release();
        test_timeout();
        test_glitch();
        test_relock();
        test_async_reset();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule

// File: doc/clk_rst_seq.md
Name: clk_rst_seq

Overview:
- Consumer side of the MMCM clock generator: supervises its lock and drives its reset.
- Runs on the free-running board reference clock.
- Pulses the MMCM reset, waits for a debounced, stable LOCKED, then releases the system reset.
- Retries on lock timeout, re-sequences on lock loss, and reports fault/status to the top level.

Parameters:
SYNC_STAGES, 2, flops in the i_locked synchronizer (min 2)
MMCM_RST_CYCLES, 8, cycles o_mmcm_reset is held high per attempt
LOCK_TIMEOUT_CYCLES, 65536, max cycles waiting for synced lock before a retry
LOCK_STABLE_CYCLES, 1024, consecutive synced-lock-high cycles required
RST_HOLD_CYCLES, 16, extra cycles o_sys_reset stays high after lock is stable
MAX_RETRIES, 3, timeouts allowed before FAULT

Ports:
i_clk  input  1  free-running reference clock (100 MHz)
i_reset  input  1  reset, asynchronous, active-high
i_locked  input  1  MMCM LOCKED, asynchronous to i_clk
i_retry  input  1  synchronous one-cycle pulse; leaves FAULT
o_mmcm_reset  output  1  drives MMCM RST
o_sys_reset  output  1  active-high system reset request; consumers synchronize deassertion
o_ready  output  1  high only in RUN
o_fault  output  1  high only in FAULT
o_relock_count  output  8  saturating count of lock losses in RUN
o_state  output  3  encoded state: MMCM_RST=0, WAIT_LOCK=1, STABLE=2, HOLD=3, RUN=4, FAULT=5

Behaviour:
- One clock domain, i_clk. All outputs are registered.
- i_reset asynchronous assert:
  - state MMCM_RST, o_mmcm_reset=1, o_sys_reset=1, o_ready=0, o_fault=0.
  - o_relock_count=0, retry counter=0, all timers=0, synchronizer flops=0.
  - Reset mid-operation aborts any state to these values.
- locked_s is i_locked passed through SYNC_STAGES flops. Only locked_s is used internally.
- MMCM_RST:
  - o_mmcm_reset=1, o_sys_reset=1.
  - After MMCM_RST_CYCLES cycles, go to WAIT_LOCK and clear the timer.
  - o_mmcm_reset falls with the transition.
- WAIT_LOCK:
  - o_mmcm_reset=0, o_sys_reset=1, timer increments.
  - locked_s=1 → STABLE, stable counter cleared.
  - Timer reaches LOCK_TIMEOUT_CYCLES-1 with locked_s=0 → retry counter +1.
    - New value == MAX_RETRIES → FAULT.
    - Otherwise → MMCM_RST.
  - Lock and timeout in the same cycle: lock wins.
- STABLE:
  - Stable counter increments while locked_s=1.
  - locked_s=0 → WAIT_LOCK. Timeout timer resumes and is not cleared, so glitching lock cannot extend the wait indefinitely.
  - Counter reaches LOCK_STABLE_CYCLES → HOLD.
- HOLD:
  - o_sys_reset=1 for RST_HOLD_CYCLES cycles, then → RUN.
  - locked_s=0 in HOLD → WAIT_LOCK, same rule as STABLE.
- RUN:
  - o_sys_reset=0, o_ready=1, retry counter cleared on entry.
  - locked_s=0 → MMCM_RST. On the next edge o_sys_reset=1 and o_ready=0.
  - o_relock_count increments, saturating at 255.
- FAULT:
  - o_fault=1, o_sys_reset=1, o_mmcm_reset=0.
  - i_locked is ignored.
  - i_retry → MMCM_RST with retry counter cleared.
  - i_retry in any other state is ignored.
- Release latency: i_locked sampled high at edge t, held high, from WAIT_LOCK → o_sys_reset low after edge t + SYNC_STAGES + LOCK_STABLE_CYCLES + RST_HOLD_CYCLES.
- Counters are sized by $clog2 of their parameter and never wrap. All compares are terminal-count.

Test Plan (SYNC_STAGES=2, MMCM_RST_CYCLES=4, LOCK_TIMEOUT_CYCLES=32, LOCK_STABLE_CYCLES=8, RST_HOLD_CYCLES=4, MAX_RETRIES=3):
1. Release i_reset; assert i_locked 10 cycles after o_mmcm_reset falls → o_mmcm_reset high exactly 4 cycles; o_sys_reset falls 14 cycles after i_locked rise; o_ready=1, o_state=4.
2. i_locked never rises → three o_mmcm_reset pulses, 32-cycle gaps; then o_fault=1, o_state=5, o_sys_reset=1. i_retry pulse → o_state=0, o_mmcm_reset=1.
3. i_locked glitches low 1 cycle mid-STABLE → stable count restarts; release occurs 14 cycles after the final rise; no MMCM reset pulse issued.
4. In RUN, drop i_locked for 3 cycles → o_sys_reset=1 and o_ready=0 within SYNC_STAGES+1 cycles; o_relock_count=1; full resequence to RUN after lock returns.
5. Assert i_reset asynchronously mid-HOLD → outputs immediately take reset values: o_sys_reset=1, o_mmcm_reset=1, o_relock_count=0.
6. Force 260 lock losses in RUN → o_relock_count saturates at 255.
